// File: rtl/instr_assembler_pkg.sv
// Shared RV32I encoding constants: opcodes, instruction formats, assembler error codes and FSM states.
package instr_assembler_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_OPCODE = 2'b01;
    localparam logic [1:0] ERR_RANGE  = 2'b10;
    localparam logic [1:0] ERR_ALIGN  = 2'b11;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_J,
        FMT_U,
        FMT_BAD
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DRAIN,
        ST_DONE
    } asm_state_e;

    function automatic fmt_e opcode_fmt(input logic [6:0] op);
        fmt_e f;
        case (op)
            OP_R:                      f = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR:  f = FMT_I;
            OP_STORE:                  f = FMT_S;
            OP_BRANCH:                 f = FMT_B;
            OP_JAL:                    f = FMT_J;
            OP_LUI, OP_AUIPC:          f = FMT_U;
            default:                   f = FMT_BAD;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/instr_assembler_pack.sv
// Combinational RV32I field packer with per-format immediate range and alignment checks.
module instr_pack
    import instr_assembler_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic [1:0]  err_code
);

    fmt_e               fmt;
    logic signed [31:0] simm;
    logic               is_shift;

    always_comb begin
        fmt      = opcode_fmt(opcode);
        simm     = imm;
        is_shift = (opcode == OP_IMM) && (funct3[1:0] == 2'b01);
        word     = '0;
        err_code = ERR_NONE;
        case (fmt)
            FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I: begin
                if (is_shift) begin
                    word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                    if (simm < 32'sd0 || simm > 32'sd31)
                        err_code = ERR_RANGE;
                end else begin
                    word = {imm[11:0], rs1, funct3, rd, opcode};
                    if (simm < -32'sd2048 || simm > 32'sd2047)
                        err_code = ERR_RANGE;
                end
            end
            FMT_S: begin
                word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                if (simm < -32'sd2048 || simm > 32'sd2047)
                    err_code = ERR_RANGE;
            end
            FMT_B: begin
                word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                // Odd offsets report as misaligned even when also out of range.
                if (imm[0])
                    err_code = ERR_ALIGN;
                else if (simm < -32'sd4096 || simm > 32'sd4094)
                    err_code = ERR_RANGE;
            end
            FMT_J: begin
                word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                if (imm[0])
                    err_code = ERR_ALIGN;
                else if (simm < -32'sd1048576 || simm > 32'sd1048574)
                    err_code = ERR_RANGE;
            end
            FMT_U: begin
                word = {imm[31:12], rd, opcode};
                if (imm[11:0] != 12'd0)
                    err_code = ERR_RANGE;
            end
            default: err_code = ERR_OPCODE;
        endcase
    end

endmodule

// File: rtl/instr_assembler.sv
// Sequential RV32I program builder: encode stage, one-entry IMEM write buffer and run-control FSM.
module instr_assembler
    import instr_assembler_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              finish,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [6:0]        req_opcode,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [2:0]        req_funct3,
    input  logic [6:0]        req_funct7,
    input  logic [31:0]       req_imm,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    asm_state_e        state;
    logic [31:0]       pack_word;
    logic [1:0]        pack_err;

    logic              vld_p1;
    logic [31:0]       word_p1;
    logic [1:0]        errc_p1;
    logic              vld_p2;
    logic [31:0]       word_p2;
    logic [ADDR_W-1:0] addr_p2;
    logic [CNT_W-1:0]  count_q;
    logic              err_q;
    logic [1:0]        err_code_q;

    logic              accept;
    logic              s1_adv;
    logic              s2_load;
    logic              s2_fire;
    logic              start_ok;

    instr_pack u_pack (
        .opcode   (req_opcode),
        .rd       (req_rd),
        .rs1      (req_rs1),
        .rs2      (req_rs2),
        .funct3   (req_funct3),
        .funct7   (req_funct7),
        .imm      (req_imm),
        .word     (pack_word),
        .err_code (pack_err)
    );

    // An errored S1 entry always leaves (it is dropped), so it never blocks on S2.
    assign s2_fire   = vld_p2 && mem_ready;
    assign s1_adv    = vld_p1 && ((errc_p1 != ERR_NONE) || !vld_p2 || mem_ready);
    assign s2_load   = s1_adv && (errc_p1 == ERR_NONE);
    assign req_ready = (state == ST_ACTIVE) && (!vld_p1 || s1_adv);
    assign accept    = req_valid && req_ready;
    assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));

    assign mem_valid = vld_p2;
    assign mem_addr  = addr_p2;
    assign mem_wdata = word_p2;
    assign count     = count_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_ACTIVE;
                        busy  <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (finish)
                        state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!vld_p1 && !vld_p2) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        state <= ST_ACTIVE;
                        busy  <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // S1: encode register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            word_p1 <= '0;
            errc_p1 <= ERR_NONE;
        end else if (accept) begin
            vld_p1  <= 1'b1;
            word_p1 <= pack_word;
            errc_p1 <= pack_err;
        end else if (s1_adv) begin
            vld_p1  <= 1'b0;
        end
    end

    // S2: memory write buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2  <= 1'b0;
            word_p2 <= '0;
        end else if (s2_load) begin
            vld_p2  <= 1'b1;
            word_p2 <= word_p1;
        end else if (s2_fire) begin
            vld_p2  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_p2    <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else if (start_ok) begin
            addr_p2    <= base_addr & ~ADDR_W'(3);
            count_q    <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            if (s2_fire) begin
                addr_p2 <= addr_p2 + ADDR_W'(4);
                count_q <= sat_inc(count_q);
            end
            if (accept && (pack_err != ERR_NONE)) begin
                err_q <= 1'b1;
                if (!err_q)
                    err_code_q <= pack_err;
            end
        end
    end

endmodule
